stage4_memory_access: RTL

STAGE4_MEMORY_ACCESS -- requirements
Module: stage4_memory_access

---
 rtl/stage4_memory_access_pkg.sv | 31 +++
 rtl/stage4_memory_access_if.sv | 17 +
 rtl/stage4_memory_access_store_lane_align.sv | 27 ++
 rtl/stage4_memory_access.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stage4_memory_access_pkg.sv
// Shared definitions for the memory-access stage: data/tag types, funct3 encodings, FSM states.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package stage4_memory_access_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  tag_t;

  // funct3 encodings for loads/stores; bits [1:0] give the access size
  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b100;
  localparam logic [2:0] MT_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Halfword needs addr[0]==0, word needs addr[1:0]==0; bytes are always aligned
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size == MT_H[1:0]) bad = addr_lo[0];
    else if (size == MT_W[1:0]) bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/stage4_memory_access_if.sv
// Memory-side request/ack bus between the memory-access stage and the data memory.
// Latency: none (wires only).
// Backpressure: the stage holds a request stable until the memory raises mem_ack.
interface stage4_memory_access_if;
  import stage4_memory_access_pkg::*;

  logic       mem_req;
  logic       mem_we;
  word_t      mem_addr;
  word_t      mem_wdata;
  logic [3:0] mem_be;
  logic       mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_be, input mem_ack);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, mem_be, output mem_ack);

endinterface

// File: rtl/stage4_memory_access_store_lane_align.sv
// Byte-enable and write-data lane placement for byte/half/word accesses.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module store_lane_align
  import stage4_memory_access_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  word_t      data,
  output logic [3:0] be,
  output word_t      wdata
);

  // Replicate the payload across every lane so the memory picks it up wherever be points
  always_comb begin
    be    = 4'b1111;
    wdata = data;
    if (size == MT_B[1:0]) begin
      be    = 4'b0001 << addr_lo;
      wdata = {4{data[7:0]}};
    end else if (size == MT_H[1:0]) begin
      be    = 4'b0011 << {addr_lo[1], 1'b0};
      wdata = {2{data[15:0]}};
    end
  end

endmodule

// File: rtl/stage4_memory_access.sv
// Pipeline stage 4: issues loads/stores to data memory and registers the result for stage 5.
// Latency: 1 cycle for non-memory ops; memory ops wait for mem_ack (or timeout after MAX_WAIT).
// Backpressure: in_ready only in IDLE with a free/draining output register; out_* hold until out_ready.
// Optional build macro: MISALIGN_TRAP_EN (trap misaligned H/W accesses instead of issuing them).
module stage4_memory_access
  import stage4_memory_access_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  word_t      alu_output,
  input  word_t      store_data,
  input  logic       is_load,
  input  logic       is_store,
  input  logic [2:0] mem_type,
  input  tag_t       rd,
  input  logic       register_writeback,
  input  logic       jump,
  input  word_t      jump_offset,
  stage4_memory_access_if.master mem,
  output logic       out_valid,
  input  logic       out_ready,
  output tag_t       out_rd,
  output logic       out_register_writeback,
  output logic       out_jump,
  output logic       out_do_load,
  output logic [2:0] out_load_type,
  output word_t      out_long_addr,
  output word_t      out_alu_output,
  output word_t      out_jump_offset,
  output logic       mem_timeout,
  output logic       misalign_trap
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;

  // Operation captured at acceptance so the memory request stays stable
  word_t      lat_alu;
  word_t      lat_data;
  logic       lat_is_load;
  logic       lat_is_store;
  logic [2:0] lat_type;
  tag_t       lat_rd;
  logic       lat_rwb;
  logic       lat_jump;
  word_t      lat_joff;

  logic accept, mem_op, bad_align;
  logic start_access, load_direct, load_mem, timeout_hit, cnt_inc;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mem_op   = is_load || is_store;

`ifdef MISALIGN_TRAP_EN
  assign bad_align = mem_op && is_misaligned(mem_type[1:0], alu_output[1:0]);
`else
  assign bad_align = 1'b0;
`endif

  // Memory request is driven from the latched op for the whole ACCESS state
  assign mem.mem_req  = (state == ACCESS);
  assign mem.mem_we   = (state == ACCESS) && lat_is_store;
  assign mem.mem_addr = {lat_alu[31:2], 2'b00};

  store_lane_align u_lane (
    .size    (lat_type[1:0]),
    .addr_lo (lat_alu[1:0]),
    .data    (lat_data),
    .be      (mem.mem_be),
    .wdata   (mem.mem_wdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-cycle control strobes; ack beats timeout in the same cycle
  always_comb begin
    state_nxt    = state;
    start_access = 1'b0;
    load_direct  = 1'b0;
    load_mem     = 1'b0;
    timeout_hit  = 1'b0;
    cnt_inc      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mem_op && !bad_align) begin
            state_nxt    = ACCESS;
            start_access = 1'b1;
          end else begin
            load_direct = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          load_mem  = 1'b1;
          state_nxt = out_ready ? IDLE : HOLD;
        end else begin
          cnt_inc = 1'b1;
          if (wait_cnt == LAST_WAIT) begin
            timeout_hit = 1'b1;
            load_mem    = 1'b1;
            state_nxt   = out_ready ? IDLE : HOLD;
          end
        end
      end
      HOLD: begin
        if (out_valid && out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wait counter: cleared on ACCESS entry, counts ACCESS cycles without ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            wait_cnt <= '0;
    else if (start_access) wait_cnt <= '0;
    else if (cnt_inc)      wait_cnt <= wait_cnt + 1'b1;
  end

  // Capture the accepted memory op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_alu      <= '0;
      lat_data     <= '0;
      lat_is_load  <= 1'b0;
      lat_is_store <= 1'b0;
      lat_type     <= '0;
      lat_rd       <= '0;
      lat_rwb      <= 1'b0;
      lat_jump     <= 1'b0;
      lat_joff     <= '0;
    end else if (start_access) begin
      lat_alu      <= alu_output;
      lat_data     <= store_data;
      lat_is_load  <= is_load && !is_store;
      lat_is_store <= is_store;
      lat_type     <= mem_type;
      lat_rd       <= rd;
      lat_rwb      <= register_writeback;
      lat_jump     <= jump;
      lat_joff     <= jump_offset;
    end
  end

  // Output register to stage 5; only reloaded when empty or being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid              <= 1'b0;
      out_rd                 <= '0;
      out_register_writeback <= 1'b0;
      out_jump               <= 1'b0;
      out_do_load            <= 1'b0;
      out_load_type          <= '0;
      out_long_addr          <= '0;
      out_alu_output         <= '0;
      out_jump_offset        <= '0;
    end else if (load_direct) begin
      out_valid              <= 1'b1;
      out_rd                 <= rd;
      out_register_writeback <= register_writeback && !bad_align;
      out_jump               <= jump;
      out_do_load            <= 1'b0;
      out_load_type          <= mem_type;
      out_long_addr          <= alu_output;
      out_alu_output         <= alu_output;
      out_jump_offset        <= jump_offset;
    end else if (load_mem) begin
      out_valid              <= 1'b1;
      out_rd                 <= lat_rd;
      out_register_writeback <= lat_rwb && !timeout_hit;
      out_jump               <= lat_jump;
      out_do_load            <= lat_is_load && !timeout_hit;
      out_load_type          <= lat_type;
      out_long_addr          <= lat_alu;
      out_alu_output         <= lat_alu;
      out_jump_offset        <= lat_joff;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           mem_timeout <= 1'b0;
    else if (timeout_hit) mem_timeout <= 1'b1;
  end

`ifdef MISALIGN_TRAP_EN
  // One-cycle trap pulse coinciding with the emitted trapped op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_trap <= 1'b0;
    else        misalign_trap <= load_direct && bad_align;
  end
`else
  assign misalign_trap = 1'b0;
`endif

endmodule
